aged_request_queue: RTL

Parametrised successor to the memory-request FIFO. It sits between the trace parser and the DRAM command scheduler. It buffers parsed CPU requests in arrival order and releases each one only after it has spent at least `MIN_AGE` CPU clock cycles in the queue. Compared with the previous generation it adds:

- a valid/ready handshake on both sides, with backpressure instead of a simulation stop when full;
- configurable depth (any value, not only powers of two) and configurable residency;
- full, empty and count status outputs;
- a synchronous flush.

---
 rtl/global_defs.sv | 19 +
 rtl/aged_request_queue_wrap_pointer.sv | 43 ++++
 rtl/aged_request_queue.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/global_defs.sv
// rtl/global_defs.sv - shared request types and sizing constants for the trace-to-DRAM path
package global_defs;

    localparam int ADDRESS_WIDTH = 32;
    localparam int QUEUE_SIZE    = 16;
    localparam int MIN_QUEUE_AGE = 100;

    typedef enum logic [1:0] {
        READ   = 2'd0,
        WRITE  = 2'd1,
        IFETCH = 2'd2
    } parsed_op_t;

    typedef struct packed {
        parsed_op_t                 opcode;
        logic [ADDRESS_WIDTH-1:0]   address;
    } queue_entry_t;

endpackage

// File: rtl/aged_request_queue_wrap_pointer.sv
// rtl/aged_request_queue_wrap_pointer.sv - index plus wrap-bit pointer for any queue depth
module wrap_pointer #(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             CPU_clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [PTR_W-1:0] ptr
);

    localparam int IDX_W = PTR_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // The index never carries into the wrap bit; it is reset explicitly at LAST_IDX.
    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (advance) begin
            if (ptr_q[IDX_W-1:0] == LAST_IDX) begin
                ptr_d = {~ptr_q[IDX_W], {IDX_W{1'b0}}};
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge CPU_clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/aged_request_queue.sv
// rtl/aged_request_queue.sv - in-order request FIFO that holds each entry for MIN_AGE cycles
module aged_request_queue
    import global_defs::*;
#(
    parameter  int DEPTH   = QUEUE_SIZE,
    parameter  int MIN_AGE = MIN_QUEUE_AGE,
    parameter  int ADDR_W  = ADDRESS_WIDTH,
    localparam int PTR_W   = $clog2(DEPTH) + 1,
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int AGE_W   = $clog2(MIN_AGE + 1)
) (
    input  logic              CPU_clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  parsed_op_t        in_opcode,
    input  logic [ADDR_W-1:0] in_address,
    output logic              out_valid,
    input  logic              out_ready,
    output parsed_op_t        out_opcode,
    output logic [ADDR_W-1:0] out_address,
    output logic [AGE_W-1:0]  out_age,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "aged_request_queue: DEPTH must be at least 2");
    end
    if (MIN_AGE < 1) begin : g_bad_age
        $fatal(1, "aged_request_queue: MIN_AGE must be at least 1");
    end

    localparam int IDX_W = PTR_W - 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MIN_AGE);

    typedef struct packed {
        parsed_op_t         opcode;
        logic [ADDR_W-1:0]  address;
    } entry_t;

    entry_t             data_q  [DEPTH];
    logic [AGE_W-1:0]   age_q   [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic               ptr_full;
    logic               ptr_empty;
    logic               push;
    logic               pop;

    assign wr_idx    = wr_ptr[IDX_W-1:0];
    assign rd_idx    = rd_ptr[IDX_W-1:0];
    assign ptr_full  = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign ptr_empty = (wr_ptr == rd_ptr);

    // Acceptance looks only at registered state, so a same-cycle pop never frees a slot early.
    assign push = in_valid && !ptr_full;
    assign pop  = out_valid && out_ready;

    wrap_pointer #(.DEPTH(DEPTH)) u_wr_ptr (
        .CPU_clk (CPU_clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .advance (push),
        .ptr     (wr_ptr)
    );

    wrap_pointer #(.DEPTH(DEPTH)) u_rd_ptr (
        .CPU_clk (CPU_clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .advance (pop),
        .ptr     (rd_ptr)
    );

    always_ff @(posedge CPU_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                age_q[i]  <= '0;
            end
            valid_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_idx == IDX_W'(i))) begin
                    data_q[i]  <= entry_t'{opcode: in_opcode, address: in_address};
                    age_q[i]   <= '0;
                    valid_q[i] <= 1'b1;
                end else if (pop && (rd_idx == IDX_W'(i))) begin
                    age_q[i]   <= '0;
                    valid_q[i] <= 1'b0;
                end else if (valid_q[i] && (age_q[i] != AGE_MAX)) begin
                    age_q[i] <= age_q[i] + AGE_W'(1);
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CPU_clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign in_ready    = !ptr_full;
    assign out_valid   = !ptr_empty && valid_q[rd_idx] && (age_q[rd_idx] == AGE_MAX);
    assign out_opcode  = data_q[rd_idx].opcode;
    assign out_address = data_q[rd_idx].address;
    assign out_age     = ptr_empty ? '0 : age_q[rd_idx];
    assign count       = count_q;
    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);

endmodule
